// File: rtl/dmem_ram.sv
// Word-addressed data memory for the load/store ports, with registered reads and byte-lane writes.
// Range errors set a sticky flag and capture the first bad address.
// Optional macro DMEM_FWD_EN returns the merged store word to a same-edge read of the same word.
module dmem_ram #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd_req_i,
   input  logic [31:0] mem_rd_addr_i,
   output logic [31:0] mem_rd_data_o,
   input  logic        mem_wr_req_i,
   input  logic [3:0]  mem_wr_sel_i,
   input  logic [31:0] mem_wr_addr_i,
   input  logic [31:0] mem_wr_data_i,
   output logic        addr_err_o,
   output logic [31:0] err_addr_o
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [31:0]       mem_q [Depth];
   logic [31:0]       rd_off, wr_off;
   logic              rd_in_range, wr_in_range;
   logic [ADDR_W-1:0] rd_idx, wr_idx;
   logic [31:0]       wr_merged;
   logic              rd_err, wr_err;
   logic [31:0]       rd_data_d, rd_data_q;
   logic              addr_err_d, addr_err_q;
   logic [31:0]       err_addr_d, err_addr_q;
   logic              unused_addr_lsbs;

   // Subtracting the base makes addresses below it wrap high, so they fail the range test.
   assign rd_off      = mem_rd_addr_i - BASE_ADDR;
   assign wr_off      = mem_wr_addr_i - BASE_ADDR;
   assign rd_in_range = (rd_off[31:ADDR_W+2] == '0);
   assign wr_in_range = (wr_off[31:ADDR_W+2] == '0);
   assign rd_idx      = rd_off[ADDR_W+1:2];
   assign wr_idx      = wr_off[ADDR_W+1:2];
   assign unused_addr_lsbs = ^{rd_off[1:0], wr_off[1:0]};

   assign rd_err = mem_rd_req_i && !rd_in_range;
   assign wr_err = mem_wr_req_i && !wr_in_range;

   always_comb begin
      wr_merged = mem_q[wr_idx];
      for (int i = 0; i < 4; i++) begin
         if (mem_wr_sel_i[i]) begin
            wr_merged[8*i +: 8] = mem_wr_data_i[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (mem_rd_req_i) begin
         if (!rd_in_range) begin
            rd_data_d = '0;
         end else begin
            rd_data_d = mem_q[rd_idx];
`ifdef DMEM_FWD_EN
            if (mem_wr_req_i && wr_in_range && (wr_idx == rd_idx)) begin
               rd_data_d = wr_merged;
            end
`endif
         end
      end
   end

   always_comb begin
      addr_err_d = addr_err_q | rd_err | wr_err;
      err_addr_d = err_addr_q;
      if (!addr_err_q) begin
         if (wr_err) begin
            err_addr_d = mem_wr_addr_i;
         end else if (rd_err) begin
            err_addr_d = mem_rd_addr_i;
         end
      end
   end

   // Array contents are not reset; only writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (!rst && mem_wr_req_i && wr_in_range) begin
         mem_q[wr_idx] <= wr_merged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         addr_err_q <= 1'b0;
         err_addr_q <= '0;
      end else begin
         rd_data_q  <= rd_data_d;
         addr_err_q <= addr_err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign mem_rd_data_o = rd_data_q;
   assign addr_err_o    = addr_err_q;
   assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_dmem_ram.sv
// Directed self-checking bench for dmem_ram; expected values are hand-derived constants.
// Build with or without DMEM_FWD_EN to match the RTL configuration.
module tb_dmem_ram;

   logic        clk;
   logic        rst;
   logic        mem_rd_req_i;
   logic [31:0] mem_rd_addr_i;
   logic [31:0] mem_rd_data_o;
   logic        mem_wr_req_i;
   logic [3:0]  mem_wr_sel_i;
   logic [31:0] mem_wr_addr_i;
   logic [31:0] mem_wr_data_i;
   logic        addr_err_o;
   logic [31:0] err_addr_o;

   int checks;
   int failures;

   dmem_ram #(
      .ADDR_W    (12),
      .BASE_ADDR (32'h0000_0000)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .mem_rd_req_i  (mem_rd_req_i),
      .mem_rd_addr_i (mem_rd_addr_i),
      .mem_rd_data_o (mem_rd_data_o),
      .mem_wr_req_i  (mem_wr_req_i),
      .mem_wr_sel_i  (mem_wr_sel_i),
      .mem_wr_addr_i (mem_wr_addr_i),
      .mem_wr_data_i (mem_wr_data_i),
      .addr_err_o    (addr_err_o),
      .err_addr_o    (err_addr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_rd_req_i = 1'b0;
      mem_wr_req_i = 1'b0;
      mem_wr_sel_i = 4'h0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data);
      mem_wr_req_i  = 1'b1;
      mem_wr_sel_i  = sel;
      mem_wr_addr_i = addr;
      mem_wr_data_i = data;
      tick();
      idle();
   endtask

   task automatic do_read(input logic [31:0] addr);
      mem_rd_req_i  = 1'b1;
      mem_rd_addr_i = addr;
      tick();
      idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_rd_req_i  = 1'b1;
      mem_rd_addr_i = 32'h0000_4000;
      mem_wr_req_i  = 1'b0;
      mem_wr_sel_i  = 4'h0;
      mem_wr_addr_i = 32'h0;
      mem_wr_data_i = 32'h0;
      tick();
      tick();
      idle();
      rst = 1'b0;
      checks++;
      if (mem_rd_data_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_rd_data got=%h exp=%h", mem_rd_data_o, 32'h0);
      end
      checks++;
      if (addr_err_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_addr_err got=%b exp=0", addr_err_o);
      end
      checks++;
      if (err_addr_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_err_addr got=%h exp=%h", err_addr_o, 32'h0);
      end
   endtask

   task automatic test_full_word();
      do_write(32'h0000_0000, 4'hF, 32'hCAFE_0000);
      do_write(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
      mem_rd_req_i  = 1'b1;
      mem_rd_addr_i = 32'h0000_0010;
      #1;
      checks++;
      if (mem_rd_data_o !== 32'h0) begin
         failures++;
         $display("FAIL rd_before_edge got=%h exp=%h", mem_rd_data_o, 32'h0);
      end
      tick();
      idle();
      checks++;
      if (mem_rd_data_o !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL rd_full_word got=%h exp=%h", mem_rd_data_o, 32'hDEAD_BEEF);
      end
      tick();
      checks++;
      if (mem_rd_data_o !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL rd_hold got=%h exp=%h", mem_rd_data_o, 32'hDEAD_BEEF);
      end
      do_read(32'h0000_0000);
      checks++;
      if (mem_rd_data_o !== 32'hCAFE_0000) begin
         failures++;
         $display("FAIL rd_word0 got=%h exp=%h", mem_rd_data_o, 32'hCAFE_0000);
      end
      do_read(32'h0000_0013);
      checks++;
      if (mem_rd_data_o !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL rd_unaligned got=%h exp=%h", mem_rd_data_o, 32'hDEAD_BEEF);
      end
   endtask

   task automatic test_byte_lanes();
      do_write(32'h0000_0020, 4'hF, 32'h1122_3344);
      do_write(32'h0000_0020, 4'b0101, 32'hAABB_CCDD);
      do_read(32'h0000_0020);
      checks++;
      if (mem_rd_data_o !== 32'h11BB_33DD) begin
         failures++;
         $display("FAIL byte_lanes got=%h exp=%h", mem_rd_data_o, 32'h11BB_33DD);
      end
      do_write(32'h0000_0020, 4'b0000, 32'hFFFF_FFFF);
      do_read(32'h0000_0020);
      checks++;
      if (mem_rd_data_o !== 32'h11BB_33DD) begin
         failures++;
         $display("FAIL sel_zero got=%h exp=%h", mem_rd_data_o, 32'h11BB_33DD);
      end
      checks++;
      if (addr_err_o !== 1'b0) begin
         failures++;
         $display("FAIL sel_zero_err got=%b exp=0", addr_err_o);
      end
   endtask

   task automatic test_same_edge();
      logic [31:0] exp_first;
`ifdef DMEM_FWD_EN
      exp_first = 32'h5555_AAAA;
`else
      exp_first = 32'h0000_0000;
`endif
      do_write(32'h0000_0030, 4'hF, 32'h0000_0000);
      mem_rd_req_i  = 1'b1;
      mem_rd_addr_i = 32'h0000_0030;
      mem_wr_req_i  = 1'b1;
      mem_wr_sel_i  = 4'hF;
      mem_wr_addr_i = 32'h0000_0030;
      mem_wr_data_i = 32'h5555_AAAA;
      tick();
      idle();
      checks++;
      if (mem_rd_data_o !== exp_first) begin
         failures++;
         $display("FAIL same_edge_rd got=%h exp=%h", mem_rd_data_o, exp_first);
      end
      // Back-to-back: read 0x30 while storing to a different word 0x34.
      mem_rd_req_i  = 1'b1;
      mem_rd_addr_i = 32'h0000_0030;
      mem_wr_req_i  = 1'b1;
      mem_wr_sel_i  = 4'hF;
      mem_wr_addr_i = 32'h0000_0034;
      mem_wr_data_i = 32'h0BAD_F00D;
      tick();
      idle();
      checks++;
      if (mem_rd_data_o !== 32'h5555_AAAA) begin
         failures++;
         $display("FAIL same_edge_next got=%h exp=%h", mem_rd_data_o, 32'h5555_AAAA);
      end
      do_read(32'h0000_0034);
      checks++;
      if (mem_rd_data_o !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL diff_word got=%h exp=%h", mem_rd_data_o, 32'h0BAD_F00D);
      end
   endtask

   task automatic test_range();
      do_write(32'h0000_4000, 4'hF, 32'h9999_9999);
      checks++;
      if (addr_err_o !== 1'b1) begin
         failures++;
         $display("FAIL oob_wr_flag got=%b exp=1", addr_err_o);
      end
      checks++;
      if (err_addr_o !== 32'h0000_4000) begin
         failures++;
         $display("FAIL oob_wr_addr got=%h exp=%h", err_addr_o, 32'h0000_4000);
      end
      do_read(32'h0000_5000);
      checks++;
      if (mem_rd_data_o !== 32'h0) begin
         failures++;
         $display("FAIL oob_rd_data got=%h exp=%h", mem_rd_data_o, 32'h0);
      end
      checks++;
      if (err_addr_o !== 32'h0000_4000) begin
         failures++;
         $display("FAIL oob_sticky got=%h exp=%h", err_addr_o, 32'h0000_4000);
      end
      do_read(32'h0000_0000);
      checks++;
      if (mem_rd_data_o !== 32'hCAFE_0000) begin
         failures++;
         $display("FAIL word0_intact got=%h exp=%h", mem_rd_data_o, 32'hCAFE_0000);
      end
      checks++;
      if (addr_err_o !== 1'b1) begin
         failures++;
         $display("FAIL flag_sticky got=%b exp=1", addr_err_o);
      end
   endtask

   task automatic test_reset_mid_write();
      do_write(32'h0000_0040, 4'hF, 32'h1234_5678);
      rst           = 1'b1;
      mem_rd_req_i  = 1'b1;
      mem_rd_addr_i = 32'h0000_0040;
      mem_wr_req_i  = 1'b1;
      mem_wr_sel_i  = 4'hF;
      mem_wr_addr_i = 32'h0000_0040;
      mem_wr_data_i = 32'hFFFF_FFFF;
      tick();
      idle();
      rst = 1'b0;
      checks++;
      if (mem_rd_data_o !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid_rd got=%h exp=%h", mem_rd_data_o, 32'h0);
      end
      checks++;
      if (err_addr_o !== 32'h0) begin
         failures++;
         $display("FAIL rst_mid_err_addr got=%h exp=%h", err_addr_o, 32'h0);
      end
      do_read(32'h0000_0040);
      checks++;
      if (mem_rd_data_o !== 32'h1234_5678) begin
         failures++;
         $display("FAIL rst_mid_wr_dropped got=%h exp=%h", mem_rd_data_o, 32'h1234_5678);
      end
      checks++;
      if (addr_err_o !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_flag got=%b exp=0", addr_err_o);
      end
   endtask

   task automatic test_both_oob();
      mem_rd_req_i  = 1'b1;
      mem_rd_addr_i = 32'h0000_8000;
      mem_wr_req_i  = 1'b1;
      mem_wr_sel_i  = 4'h0;
      mem_wr_addr_i = 32'hFFFF_FFFC;
      mem_wr_data_i = 32'h0;
      tick();
      idle();
      checks++;
      if (addr_err_o !== 1'b1) begin
         failures++;
         $display("FAIL both_oob_flag got=%b exp=1", addr_err_o);
      end
      checks++;
      if (err_addr_o !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL both_oob_wr_wins got=%h exp=%h", err_addr_o, 32'hFFFF_FFFC);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_full_word();
      test_byte_lanes();
      test_same_edge();
      test_range();
      test_reset_mid_write();
      test_both_oob();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_ram.md
Name: dmem_ram

Overview:
- Data memory that sits directly downstream of the open_risc_v core's load/store ports.
- Consumes the read-request signals issued in ID and the write-request/byte-select signals issued in EX.
- Returns load data registered, one cycle after the request, so it is valid while the load is in EX.
- Adds address range checking with a sticky error flag and first-error address capture.

Parameters:
- ADDR_W, 12, word-index width; depth = 2^ADDR_W 32-bit words (16 KiB default)
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 2^(ADDR_W+2)-aligned

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- mem_rd_req_i  in  1  load request from ID
- mem_rd_addr_i  in  32  load byte address
- mem_rd_data_o  out  32  registered load word
- mem_wr_req_i  in  1  store request from EX
- mem_wr_sel_i  in  4  byte-lane enables; bit i covers data[8i+7:8i]
- mem_wr_addr_i  in  32  store byte address
- mem_wr_data_i  in  32  store data, already lane-aligned by the core
- addr_err_o  out  1  sticky out-of-range access flag
- err_addr_o  out  32  byte address of the first out-of-range access

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. Every state element samples `rst` only on the rising edge of `clk`.
- Reset values: mem_rd_data_o=0, addr_err_o=0, err_addr_o=0.
  - Array contents are NOT reset.
  - While rst=1, writes are suppressed and reads do not update mem_rd_data_o.
  - Reset asserted mid-stream takes priority over a same-edge request.
- Address decode:
  - in_range = (addr - BASE_ADDR) < 2^(ADDR_W+2), computed unsigned in 32 bits so wrap-around below BASE_ADDR counts as out of range.
  - Word index = (addr - BASE_ADDR)[ADDR_W+1:2].
  - addr[1:0] is ignored; the core handles sub-word alignment.
- Read:
  - On an edge with mem_rd_req_i=1, mem_rd_data_o <= mem[idx], giving a latency of exactly 1 cycle.
  - An out-of-range read loads 0.
  - On an edge with mem_rd_req_i=0, mem_rd_data_o holds its value.
  - Back-to-back reads are supported every cycle with no stall.
- Write:
  - On an edge with mem_wr_req_i=1 and in range, each lane i with sel[i]=1 takes data[8i+7:8i]; lanes with sel[i]=0 are unchanged.
  - sel=4'b0000 writes nothing and is not an error.
  - An out-of-range write is dropped.
- Simultaneous read and write to the same word index on the same edge: result depends on DMEM_FWD_EN (see Optional Feature).
- Simultaneous accesses to different words are independent.
- Error capture:
  - An out-of-range access is any edge where rd_req or wr_req (with any sel) targets an out-of-range address.
  - On that edge addr_err_o <= 1.
  - If addr_err_o was 0, err_addr_o <= the offending address. If both read and write are out of range on the same edge, the write address wins.
  - Subsequent errors do not overwrite err_addr_o.
  - The flag clears only on rst.
- The block never back-pressures the core; there is no ready or stall output.

Optional Feature:
- Macro: DMEM_FWD_EN.
- Defined (write-first): on a same-edge read and write to the same in-range word, mem_rd_data_o returns the merged word, i.e. new bytes on enabled lanes and old bytes elsewhere.
- Undefined (read-first): mem_rd_data_o returns the pre-write word; the new data is visible to the next read.
- Rationale: the core issues the load in ID while the older store is in EX, so forwarding removes the store-then-load hazard.
- Array write behaviour is identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles, then release. Expect mem_rd_data_o=0, addr_err_o=0, err_addr_o=0.
- Full-word round trip: write 0x0000_0010 sel=4'hF data=0xDEAD_BEEF, then read 0x0000_0010. mem_rd_data_o=0xDEAD_BEEF exactly 1 cycle after the read edge. Reading with addr 0x0000_0013 returns the same word.
- Byte lanes: preload 0x1122_3344 at 0x20, write sel=4'b0101 data=0xAABB_CCDD, read 0x20. Expect 0x11BB_33DD.
- Same-edge read/write to 0x30, old value 0x0, write data 0x5555_AAAA sel=4'hF:
  - With DMEM_FWD_EN: read returns 0x5555_AAAA.
  - Without DMEM_FWD_EN: read returns 0x0, and the next read returns 0x5555_AAAA.
- Range check (ADDR_W=12, BASE=0):
  - Write to 0x0000_4000 is dropped and addr_err_o=1, err_addr_o=0x0000_4000.
  - A later read to 0x0000_5000 returns 0 and err_addr_o is unchanged.
  - Word 0 is unaffected.
- Reset mid-write: assert rst on the same edge as a write of 0xFFFF_FFFF to 0x40 (old value 0x1234_5678). After release, reading 0x40 returns 0x1234_5678 and addr_err_o=0.
